fire_ctrl: RTL and testbench
============================

# fire_ctrl

Sequences player shots against the 10×10 grid-state memory and shares that memory's single port with the display scan path. It owns the cursor position, edge-detects the five buttons, and moves the cursor with wrap-around. On each fire it runs a read-modify-write of the targeted cell and tracks hits until game over. It sits between the button inputs, the grid RAM, and the VGA output stage, which supplies the scan cell index and consumes the cursor index and the per-cell display state.

## Interface
- GRID_SIZE, 10, cells per row/column
- CELLS, 100, total cells (GRID_SIZE²)
- SLOT_PERIOD, 4, memory-port slot cycle; controller owns last slot
- SHIP_CELLS, 17, hits required for game over
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- btn_up, btn_down, btn_left, btn_right, btn_fire  in  1 each  debounced button levels
- scan_cor  in  7  cell index currently scanned by display
- cell_state_disp  out  2  registered cell state for scan_cor
- cursor_cor  out  7  cursor cell index (row*GRID_SIZE+col)
- mem_addr  out  7  grid RAM address
- mem_we  out  1  grid RAM write enable
- mem_wdata  out  2  grid RAM write data
- mem_rdata  in  2  grid RAM read data, valid cycle after address
- shot_valid  out  1  one-cycle pulse, shot resolved
- shot_hit  out  1  qualified by shot_valid: cell was SHIP
- shot_repeat  out  1  qualified by shot_valid: cell already MISS/HIT
- hits_count  out  5  accumulated hits
- game_over  out  1  sticky, hits_count == SHIP_CELLS

## Operation
- Cell encoding: EMPTY=0, SHIP=1, MISS=2, HIT=3.
- Button edge = level 1 now, 0 in previous cycle; one-flop history per button.
- Cursor moves on edges in any state; at most one move per cycle; priority up>down>left>right.
- Wrap: right at col 9 → col 0 same row; left at col 0 → col 9; down at row 9 → row 0; up at row 0 → row 9.
- Fire edge accepted only in IDLE and !game_over; otherwise dropped. Target = cursor_cor latched at acceptance.
- FSM: IDLE → RD_REQ (on fire) → RD_WAIT (after granted read slot) → DECIDE → WR_REQ (EMPTY/SHIP) or DONE (MISS/HIT) → DONE (after granted write slot) → IDLE.
- DECIDE: EMPTY → wdata MISS; SHIP → wdata HIT; MISS/HIT → no write, shot_repeat=1.
- DONE: shot_valid=1 for one cycle. On a hit, hits_count increments in the same cycle. game_over sets when hits_count reaches SHIP_CELLS.
- Arbitration: free-running slot_cnt 0..SLOT_PERIOD-1. Controller drives the port only when slot_cnt==SLOT_PERIOD-1 and state is RD_REQ/WR_REQ. In every other cycle, mem_addr=scan_cor (or 0 if scan_cor≥CELLS) and mem_we=0.
- Display capture: a display-owned cycle at t loads cell_state_disp from mem_rdata at the end of t+1. scan_cor≥CELLS loads EMPTY. After a controller-owned cycle, cell_state_disp holds.

## Timing
- Reset: state IDLE, slot_cnt 0, cursor_cor 0, cell_state_disp 0, mem_addr 0, mem_we 0, mem_wdata 0, shot_* 0, hits_count 0, game_over 0, button history 0.
- mem_addr/mem_we/mem_wdata are registered: decisions in cycle t appear at t+1.
- Cursor update is visible the cycle after the edge cycle.
- Fire latency, edge to shot_valid: ≤ 2·SLOT_PERIOD + 4 cycles (write path), ≤ SLOT_PERIOD + 4 (repeat path).
- Reset asserted mid-shot: any pending write is abandoned; mem_we=0 immediately (async).
- hits_count saturates at SHIP_CELLS.

## Structure
- Package grid_pkg: cell-state localparams (EMPTY/SHIP/MISS/HIT), GRID_SIZE, CELLS, FSM state encoding.
- Sub-module cursor_mover: edge inputs plus current index → next index with wrap. Purely row/col arithmetic; row/col held as separate 4-bit fields internally.
- Top holds the FSM, slot counter, arbitration mux, display capture, and counters.

## Test plan
- Reset low mid-run → all outputs 0, cursor_cor 0. After release, slot_cnt restarts at 0.
- Ten right edges from cursor 0 → cursor 1..9, then 0. One up edge from 0 → 90. Simultaneous up+left at 45 → 35.
- Cell 23=SHIP, cursor 23, fire → exactly one read of 23 and one write (23, HIT), both on slot 3. shot_valid with shot_hit=1, hits_count=1.
- Fire again at 23 → read only, no write. shot_valid with shot_repeat=1, shot_hit=0, hits_count unchanged. Fire during busy → ignored.
- scan_cor sweeps 0..99, then 127 → cell_state_disp matches RAM two cycles later and holds across controller-owned cycles. 127 → mem_addr 0, cell_state_disp EMPTY.
- Preload 17 SHIP cells, fire on all → game_over=1 after 17th shot_valid, further fires ignored. Reset asserted during WR_REQ → no write observed.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared constants and encodings for the battleship grid memory and the
// shot sequencer.
package grid_pkg;
  localparam int GRID_SIZE   = 10;
  localparam int CELLS       = GRID_SIZE * GRID_SIZE;
  localparam int SLOT_PERIOD = 4;
  localparam int SHIP_CELLS  = 17;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] SHIP  = 2'd1;
  localparam logic [1:0] MISS  = 2'd2;
  localparam logic [1:0] HIT   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_REQ, ST_RD_WAIT, ST_DECIDE, ST_WR_REQ, ST_DONE
  } state_t;
endpackage

// File: rtl/cursor_mover.sv
// Next cursor index from one-cycle move strobes; wraps on every grid edge.
// Priority up > down > left > right.
module cursor_mover
  import grid_pkg::*;
(
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic [6:0] cur,
  output logic [6:0] nxt
);
  localparam logic [3:0] LAST = 4'(GRID_SIZE - 1);

  logic [3:0] row, col, row_n, col_n;

  assign row = 4'(cur / 7'(GRID_SIZE));
  assign col = 4'(cur % 7'(GRID_SIZE));

  always_comb begin
    row_n = row;
    col_n = col;
    if (up)         row_n = (row == 4'd0) ? LAST : row - 4'd1;
    else if (down)  row_n = (row == LAST) ? 4'd0 : row + 4'd1;
    else if (left)  col_n = (col == 4'd0) ? LAST : col - 4'd1;
    else if (right) col_n = (col == LAST) ? 4'd0 : col + 4'd1;
  end

  assign nxt = 7'(row_n) * 7'(GRID_SIZE) + 7'(col_n);
endmodule

// File: rtl/fire_ctrl.sv
// Shot sequencer: cursor, fire read-modify-write on the grid RAM, and
// time-slotted sharing of the single RAM port with the display scan.
module fire_ctrl
  import grid_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fire,
  input  logic [6:0] scan_cor,
  output logic [1:0] cell_state_disp,
  output logic [6:0] cursor_cor,
  output logic [6:0] mem_addr,
  output logic       mem_we,
  output logic [1:0] mem_wdata,
  input  logic [1:0] mem_rdata,
  output logic       shot_valid,
  output logic       shot_hit,
  output logic       shot_repeat,
  output logic [4:0] hits_count,
  output logic       game_over
);
  localparam int SW = $clog2(SLOT_PERIOD);

  logic [4:0]    btn, btn_q, edg;
  logic [SW-1:0] slot_cnt;
  logic          slot_last, ctrl_drive, scan_oob;
  state_t        state;
  logic [6:0]    target, cur_nxt;
  logic [1:0]    wdata_q;
  logic          hit_q;
  // own_q/oob_q describe the address now on the port; cap_* is one stage later
  // when the matching read data arrives.
  logic          own_q, oob_q, cap_vld, cap_oob;

  assign btn        = {btn_fire, btn_right, btn_left, btn_down, btn_up};
  assign edg        = btn & ~btn_q;
  assign slot_last  = (slot_cnt == SW'(SLOT_PERIOD - 1));
  assign ctrl_drive = slot_last && (state == ST_RD_REQ || state == ST_WR_REQ);
  assign scan_oob   = (scan_cor >= 7'(CELLS));

  cursor_mover u_mv (
    .up(edg[0]), .down(edg[1]), .left(edg[2]), .right(edg[3]),
    .cur(cursor_cor), .nxt(cur_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q           <= '0;
      slot_cnt        <= '0;
      cursor_cor      <= '0;
      mem_addr        <= '0;
      mem_we          <= 1'b0;
      mem_wdata       <= '0;
      own_q           <= 1'b0;
      oob_q           <= 1'b0;
      cap_vld         <= 1'b0;
      cap_oob         <= 1'b0;
      cell_state_disp <= EMPTY;
      state           <= ST_IDLE;
      target          <= '0;
      wdata_q         <= '0;
      hit_q           <= 1'b0;
      shot_valid      <= 1'b0;
      shot_hit        <= 1'b0;
      shot_repeat     <= 1'b0;
      hits_count      <= '0;
      game_over       <= 1'b0;
    end else begin
      btn_q    <= btn;
      slot_cnt <= slot_last ? '0 : slot_cnt + 1'b1;
      if (|edg[3:0]) cursor_cor <= cur_nxt;

      if (ctrl_drive) begin
        mem_addr  <= target;
        mem_we    <= (state == ST_WR_REQ);
        mem_wdata <= wdata_q;
        own_q     <= 1'b0;
      end else begin
        mem_addr  <= scan_oob ? 7'd0 : scan_cor;
        mem_we    <= 1'b0;
        mem_wdata <= '0;
        own_q     <= 1'b1;
        oob_q     <= scan_oob;
      end
      cap_vld <= own_q;
      cap_oob <= oob_q;
      if (cap_vld) cell_state_disp <= cap_oob ? EMPTY : mem_rdata;

      shot_valid <= 1'b0;
      case (state)
        ST_IDLE:
          if (edg[4] && !game_over) begin
            target <= cursor_cor;
            state  <= ST_RD_REQ;
          end
        ST_RD_REQ:  if (slot_last) state <= ST_RD_WAIT;
        ST_RD_WAIT: state <= ST_DECIDE;
        ST_DECIDE: begin
          hit_q   <= (mem_rdata == SHIP);
          wdata_q <= (mem_rdata == SHIP) ? HIT : MISS;
          if (mem_rdata[1]) begin
            state       <= ST_DONE;
            shot_valid  <= 1'b1;
            shot_hit    <= 1'b0;
            shot_repeat <= 1'b1;
          end else begin
            state <= ST_WR_REQ;
          end
        end
        ST_WR_REQ:
          if (slot_last) begin
            state       <= ST_DONE;
            shot_valid  <= 1'b1;
            shot_hit    <= hit_q;
            shot_repeat <= 1'b0;
            if (hit_q && hits_count < 5'(SHIP_CELLS)) begin
              hits_count <= hits_count + 5'd1;
              if (hits_count == 5'(SHIP_CELLS - 1)) game_over <= 1'b1;
            end
          end
        ST_DONE: begin
          shot_hit    <= 1'b0;
          shot_repeat <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fire_ctrl.sv
// Bench for fire_ctrl: grid RAM model, expected-shot scoreboard drained by a
// monitor on shot_valid, plus directed cursor/display/reset checks.
module tb_fire_ctrl;
  import grid_pkg::*;

  typedef struct packed {
    logic       hit;
    logic       rep;
    logic [4:0] hits;
    logic       go;
  } exp_t;

  localparam logic [4:0] U = 5'b00001, D = 5'b00010, L = 5'b00100,
                         R = 5'b01000, F = 5'b10000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] btn = '0;
  logic [6:0] scan_cor = 7'd127;
  logic [1:0] cell_state_disp, mem_wdata, mem_rdata;
  logic [6:0] cursor_cor, mem_addr;
  logic       mem_we, shot_valid, shot_hit, shot_repeat, game_over;
  logic [4:0] hits_count;

  logic [1:0] ram [128];
  exp_t       sb [$];
  exp_t       e;
  int         checks = 0, fails = 0;
  int         wr_cnt = 0, rd_cnt = 0, watch = 0, cur_m = 0, bad = 0;
  logic [6:0] wr_addr;
  logic [1:0] wr_data;
  time        t_fire, t_shot;

  always #5 clk = ~clk;

  fire_ctrl dut (
    .clk(clk), .reset(reset),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]),
    .btn_right(btn[3]), .btn_fire(btn[4]),
    .scan_cor(scan_cor), .cell_state_disp(cell_state_disp),
    .cursor_cor(cursor_cor), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .shot_valid(shot_valid), .shot_hit(shot_hit), .shot_repeat(shot_repeat),
    .hits_count(hits_count), .game_over(game_over)
  );

  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Monitor: port activity and scoreboard drain.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_cnt++;
      wr_addr = mem_addr;
      wr_data = mem_wdata;
    end
    if (reset && !mem_we && mem_addr == 7'(watch)) rd_cnt++;
    if (reset && shot_valid) begin
      t_shot = $time;
      if (sb.size() == 0) chk("unexpected_shot", 1, 0);
      else begin
        e = sb.pop_front();
        chk("shot_hit", shot_hit, e.hit);
        chk("shot_repeat", shot_repeat, e.rep);
        chk("hits_count", hits_count, e.hits);
        chk("game_over", game_over, e.go);
      end
    end
  end

  task automatic press(input logic [4:0] m);
    btn = m;
    @(negedge clk);
    btn = '0;
    @(negedge clk);
  endtask

  task automatic go_to(input int c);
    while (cur_m % 10 != c % 10) begin
      press(R);
      cur_m = (cur_m / 10) * 10 + (cur_m % 10 + 1) % 10;
    end
    while (cur_m / 10 != c / 10) begin
      press(D);
      cur_m = ((cur_m / 10 + 1) % 10) * 10 + cur_m % 10;
    end
    chk("goto_cursor", cursor_cor, c);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  task automatic fire(input logic h, input logic r, input int hits, input logic go,
                      input int maxlat);
    sb.push_back('{hit: h, rep: r, hits: 5'(hits), go: go});
    t_fire = $time;
    press(F);
    drain(40);
    chk("fire_latency_ok", ((t_shot - t_fire) / 10) <= maxlat, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cursor", cursor_cor, 0);
    chk("rst_disp", cell_state_disp, 0);
    chk("rst_shot", {shot_valid, shot_hit, shot_repeat}, 0);
    chk("rst_hits", hits_count, 0);
    chk("rst_game_over", game_over, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("slot_restart", dut.slot_cnt, 0);
    @(negedge clk);
    cur_m = 0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ram[i] = EMPTY;
    ram[23] = SHIP;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    press(R);
    do_reset();

    // Cursor wrap and priority
    for (int i = 1; i <= 10; i++) begin
      press(R);
      chk("right_wrap", cursor_cor, i % 10);
    end
    press(U);
    chk("up_wrap", cursor_cor, 90);
    cur_m = 90;
    go_to(45);
    press(U | L);
    chk("up_over_left", cursor_cor, 35);
    cur_m = 35;

    // First shot on a ship: one read and one HIT write
    go_to(23);
    watch = 23; rd_cnt = 0; wr_cnt = 0;
    fire(1'b1, 1'b0, 1, 1'b0, 2 * SLOT_PERIOD + 4);
    chk("hit_reads", rd_cnt, 1);
    chk("hit_writes", wr_cnt, 1);
    chk("hit_wr_addr", wr_addr, 23);
    chk("hit_wr_data", wr_data, HIT);
    chk("ram23_hit", ram[23], HIT);

    // Repeat shot, plus a fire while busy that must be dropped
    rd_cnt = 0; wr_cnt = 0;
    sb.push_back('{hit: 1'b0, rep: 1'b1, hits: 5'd1, go: 1'b0});
    t_fire = $time;
    press(F);
    press(F);
    drain(40);
    chk("repeat_latency_ok", ((t_shot - t_fire) / 10) <= SLOT_PERIOD + 4, 1);
    repeat (30) @(negedge clk);
    chk("repeat_reads", rd_cnt, 1);
    chk("repeat_writes", wr_cnt, 0);

    // Display sweep
    for (int i = 0; i < 100; i++) ram[i] = 2'((i + i / 10) % 4);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      scan_cor = 7'(i);
      repeat (4) @(negedge clk);
      if (cell_state_disp !== ram[i]) bad++;
    end
    chk("disp_sweep_bad", bad, 0);
    scan_cor = 7'd98;
    repeat (4) @(negedge clk);
    chk("disp_98", cell_state_disp, 3);
    scan_cor = 7'd127;
    repeat (4) @(negedge clk);
    chk("disp_oob", cell_state_disp, EMPTY);
    chk("addr_oob", mem_addr, 0);

    // Display holds its cell while the controller borrows the port
    scan_cor = 7'd50;
    repeat (4) @(negedge clk);
    sb.push_back('{hit: 1'b1, rep: 1'b0, hits: 5'd2, go: 1'b0});
    press(F);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (cell_state_disp !== 2'd3) bad++;
      @(negedge clk);
    end
    chk("disp_hold_bad", bad, 0);
    drain(10);
    scan_cor = 7'd127;

    // Game over after 17 hits
    do_reset();
    for (int i = 0; i < 128; i++) ram[i] = (i < SHIP_CELLS) ? SHIP : EMPTY;
    for (int k = 0; k < SHIP_CELLS; k++) begin
      go_to(k);
      fire(1'b1, 1'b0, k + 1, k == SHIP_CELLS - 1, 2 * SLOT_PERIOD + 4);
    end
    go_to(SHIP_CELLS);
    wr_cnt = 0;
    press(F);
    repeat (30) @(negedge clk);
    chk("go_no_write", wr_cnt, 0);
    chk("go_hits", hits_count, SHIP_CELLS);
    chk("go_sticky", game_over, 1);

    // Reset while a write is pending
    do_reset();
    ram[0] = EMPTY;
    wr_cnt = 0;
    press(F);
    for (int i = 0; i < 20 && dut.state != ST_WR_REQ; i++) @(negedge clk);
    chk("reach_wr_req", dut.state == ST_WR_REQ, 1);
    reset = 1'b0;
    #1;
    chk("abort_mem_we", mem_we, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_writes", wr_cnt, 0);
    chk("abort_ram0", ram[0], EMPTY);
    chk("abort_no_shot", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
